// File: rtl/fll_cfg_pkg.sv
// ----------------------------------------------------------------------------
// fll_cfg_pkg
// Shared types and constants for the APB-to-FLL configuration master.
//   fll_state_e   : handshake FSM states
//   fll_acc_e     : classification of an APB access by word address
//   FLL_REG0..3   : byte offsets of the four FLL configuration registers
//   STATUS        : byte offset of the local status register
//   STATUS_*_BIT  : bit positions inside STATUS
// ----------------------------------------------------------------------------
package fll_cfg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_DROP,
        ST_DONE,
        ST_ERR
    } fll_state_e;

    typedef enum logic [1:0] {
        ACC_FLL,
        ACC_STATUS,
        ACC_BAD
    } fll_acc_e;

    localparam logic [4:0] FLL_REG0 = 5'h00;
    localparam logic [4:0] FLL_REG1 = 5'h04;
    localparam logic [4:0] FLL_REG2 = 5'h08;
    localparam logic [4:0] FLL_REG3 = 5'h0C;
    localparam logic [4:0] STATUS   = 5'h10;

    localparam int STATUS_LOCK_BIT = 0;
    localparam int STATUS_TMO_BIT  = 1;

    // Only PADDR[4:2] is decoded, so callers pass the word index.
    function automatic fll_acc_e decode_access(input logic [2:0] word_idx);
        fll_acc_e acc;
        case (word_idx)
            FLL_REG0[4:2], FLL_REG1[4:2],
            FLL_REG2[4:2], FLL_REG3[4:2]: acc = ACC_FLL;
            STATUS[4:2]:                  acc = ACC_STATUS;
            default:                      acc = ACC_BAD;
        endcase
        return acc;
    endfunction

endpackage

// File: rtl/apb_fll_cfg_master_if.sv
// ----------------------------------------------------------------------------
// apb_fll_cfg_master_if
// APB3 bus bundle for the FLL configuration master.
//   master modport : drives PADDR/PWDATA/PWRITE/PSEL/PENABLE
//   slave  modport : drives PRDATA/PREADY/PSLVERR
// ----------------------------------------------------------------------------
interface apb_fll_cfg_master_if #(
    parameter int unsigned ADDR_WIDTH = 12
);
    logic [ADDR_WIDTH-1:0] PADDR;
    logic [31:0]           PWDATA;
    logic                  PWRITE;
    logic                  PSEL;
    logic                  PENABLE;
    logic [31:0]           PRDATA;
    logic                  PREADY;
    logic                  PSLVERR;

    modport master (
        output PADDR, PWDATA, PWRITE, PSEL, PENABLE,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PADDR, PWDATA, PWRITE, PSEL, PENABLE,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/cdc_sync_2ff.sv
// ----------------------------------------------------------------------------
// cdc_sync_2ff
// Two-flop synchronizer for independent single-bit level signals.
//   i_clk : destination clock
//   i_rst : asynchronous active-high reset (outputs 0)
//   i_d   : asynchronous inputs
//   o_q   : synchronized outputs, two destination clocks of latency
// Each bit is synchronized on its own; no coherency between bits is implied.
// ----------------------------------------------------------------------------
module cdc_sync_2ff #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);
    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    // NOTE: sequential state uses non-blocking assignments so both stages
    // sample their inputs from before the edge; blocking would collapse them.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;
endmodule

// File: rtl/apb_fll_cfg_master.sv
// ----------------------------------------------------------------------------
// apb_fll_cfg_master
// APB slave that turns accesses to FLL registers 0..3 into a 4-phase
// req/ack transaction on the FLL configuration port, plus a local STATUS.
//   clk_i, rst_i   : SoC clock, asynchronous active-high reset
//   apb            : APB slave port (PADDR[4:2] decoded)
//   fll_req_o      : configuration request
//   fll_wrn_o      : 0 = write, 1 = read (idle value 1)
//   fll_add_o      : FLL register index
//   fll_data_o     : write data, held between transactions
//   fll_ack_i      : acknowledge from the FLL clock domain
//   fll_r_data_i   : read data, stable while ack is high
//   fll_lock_i     : FLL lock, from the FLL clock domain
// STATUS: bit0 lock (RO), bit1 timeout sticky (W1C).
// ----------------------------------------------------------------------------
module apb_fll_cfg_master
    import fll_cfg_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned APB_ADDR_WIDTH = 12
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    apb_fll_cfg_master_if.slave  apb,
    output logic                 fll_req_o,
    output logic                 fll_wrn_o,
    output logic [1:0]           fll_add_o,
    output logic [31:0]          fll_data_o,
    input  logic                 fll_ack_i,
    input  logic [31:0]          fll_r_data_i,
    input  logic                 fll_lock_i
);
    localparam int unsigned      CNT_W    = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    fll_state_e         r_state;
    fll_state_e         w_state_nxt;
    logic               r_req;
    logic               r_wrn;
    logic [1:0]         r_add;
    logic [31:0]        r_data;
    logic [31:0]        r_prdata;
    logic               r_pready;
    logic               r_pslverr;
    logic               r_tmo_sticky;
    logic [CNT_W-1:0]   r_cnt;

    logic [1:0]         w_sync_q;
    logic               w_ack_s;
    logic               w_lock_s;
    logic               w_access;
    fll_acc_e           w_acc;
    logic [31:0]        w_status;
    logic               w_cnt_hit;
    logic               w_cnt_clr;
    logic               w_start;
    logic               w_tmo;
    logic               w_w1c;
    logic               w_prdata_load;
    logic [31:0]        w_prdata_val;
    logic [APB_ADDR_WIDTH-4:0] w_unused_paddr;

    cdc_sync_2ff #(.WIDTH(2)) u_sync (
        .i_clk (clk_i),
        .i_rst (rst_i),
        .i_d   ({fll_lock_i, fll_ack_i}),
        .o_q   (w_sync_q)
    );
    assign w_ack_s  = w_sync_q[0];
    assign w_lock_s = w_sync_q[1];

    assign w_access       = apb.PSEL & apb.PENABLE;
    assign w_acc          = decode_access(apb.PADDR[4:2]);
    assign w_unused_paddr = {apb.PADDR[APB_ADDR_WIDTH-1:5], apb.PADDR[1:0]};
    assign w_cnt_hit      = (r_cnt == CNT_LAST);

    always_comb begin
        w_status                  = '0;
        w_status[STATUS_LOCK_BIT] = w_lock_s;
        w_status[STATUS_TMO_BIT]  = r_tmo_sticky;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    // NOTE: every signal written here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        w_state_nxt   = r_state;
        w_start       = 1'b0;
        w_tmo         = 1'b0;
        w_w1c         = 1'b0;
        w_prdata_load = 1'b0;
        w_prdata_val  = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_access) begin
                    w_prdata_load = 1'b1;
                    case (w_acc)
                        ACC_STATUS: begin
                            w_state_nxt = ST_DONE;
                            if (apb.PWRITE) w_w1c        = apb.PWDATA[STATUS_TMO_BIT];
                            else            w_prdata_val = w_status;
                        end
                        ACC_FLL: begin
                            // An ack still high from a previous transaction means
                            // the FLL side is out of step; refuse to start.
                            if (w_ack_s) begin
                                w_state_nxt = ST_ERR;
                            end else begin
                                w_state_nxt = ST_REQ;
                                w_start     = 1'b1;
                            end
                        end
                        default: w_state_nxt = ST_ERR;
                    endcase
                end
            end
            ST_REQ: begin
                if (w_ack_s) begin
                    w_state_nxt   = ST_DROP;
                    w_prdata_load = 1'b1;
                    w_prdata_val  = r_wrn ? fll_r_data_i : '0;
                end else if (w_cnt_hit) begin
                    w_state_nxt = ST_ERR;
                    w_tmo       = 1'b1;
                end
            end
            ST_DROP: begin
                if (!w_ack_s) begin
                    w_state_nxt = ST_DONE;
                end else if (w_cnt_hit) begin
                    w_state_nxt = ST_ERR;
                    w_tmo       = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Phase timer restarts whenever a new waiting phase is entered.
    assign w_cnt_clr = (w_state_nxt != r_state) &&
                       ((w_state_nxt == ST_REQ) || (w_state_nxt == ST_DROP));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_req        <= 1'b0;
            r_wrn        <= 1'b1;
            r_add        <= '0;
            r_data       <= '0;
            r_prdata     <= '0;
            r_pready     <= 1'b0;
            r_pslverr    <= 1'b0;
            r_tmo_sticky <= 1'b0;
            r_cnt        <= '0;
        end else begin
            // Outputs follow the next state so they are glitch-free flops.
            r_req     <= (w_state_nxt == ST_REQ);
            r_pready  <= (w_state_nxt == ST_DONE) || (w_state_nxt == ST_ERR);
            r_pslverr <= (w_state_nxt == ST_ERR);

            if (w_start) begin
                r_add <= apb.PADDR[3:2];
                r_wrn <= ~apb.PWRITE;
                if (apb.PWRITE) r_data <= apb.PWDATA;
            end else if ((r_state == ST_DONE) || (r_state == ST_ERR)) begin
                r_wrn <= 1'b1;
            end

            if (w_prdata_load) r_prdata <= w_prdata_val;

            // A timeout set takes priority over a coincident W1C clear.
            if (w_tmo)      r_tmo_sticky <= 1'b1;
            else if (w_w1c) r_tmo_sticky <= 1'b0;

            if (w_cnt_clr) begin
                r_cnt <= '0;
            end else if ((r_state == ST_REQ) || (r_state == ST_DROP)) begin
                if (r_cnt != CNT_MAX) r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign fll_req_o   = r_req;
    assign fll_wrn_o   = r_wrn;
    assign fll_add_o   = r_add;
    assign fll_data_o  = r_data;
    assign apb.PRDATA  = r_prdata;
    assign apb.PREADY  = r_pready;
    assign apb.PSLVERR = r_pslverr;
endmodule

// File: tb/tb_apb_fll_cfg_master.sv
// ----------------------------------------------------------------------------
// tb_apb_fll_cfg_master
// Self-checking bench: directed scenarios plus randomized APB traffic against
// an FLL responder on its own reference clock. Expected values come from a
// register-file model of the FLL and the STATUS semantics.
// ----------------------------------------------------------------------------
module tb_apb_fll_cfg_master;
    localparam int unsigned TMO = 16;

    typedef enum int {M_LOOP, M_LAT, M_STUCK0, M_STUCK1, M_HOLD} resp_mode_e;

    logic        clk_i;
    logic        rst_i;
    logic        ref_clk;
    logic        fll_req_o;
    logic        fll_wrn_o;
    logic [1:0]  fll_add_o;
    logic [31:0] fll_data_o;
    logic        fll_ack_i;
    logic [31:0] fll_r_data_i;
    logic        fll_lock_i;

    apb_fll_cfg_master_if #(.ADDR_WIDTH(12)) bus ();

    apb_fll_cfg_master #(.TIMEOUT_CYCLES(TMO), .APB_ADDR_WIDTH(12)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .apb          (bus),
        .fll_req_o    (fll_req_o),
        .fll_wrn_o    (fll_wrn_o),
        .fll_add_o    (fll_add_o),
        .fll_data_o   (fll_data_o),
        .fll_ack_i    (fll_ack_i),
        .fll_r_data_i (fll_r_data_i),
        .fll_lock_i   (fll_lock_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;
    initial ref_clk = 1'b0;
    always #7 ref_clk = ~ref_clk;

    int n_compared   = 0;
    int n_mismatched = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // ---------------- FLL responder (reference clock domain) ----------------
    resp_mode_e  mode = M_LOOP;
    int          lat  = 0;
    int          lat_cnt = 0;
    logic        lat_ack = 1'b0;
    logic [31:0] resp_rdata = '0;
    logic [31:0] fll_mem [4];

    assign fll_ack_i = (mode == M_LOOP)   ? fll_req_o :
                       (mode == M_STUCK1) ? 1'b1 :
                       (mode == M_STUCK0) ? 1'b0 : lat_ack;
    assign fll_r_data_i = (mode == M_LOOP) ? 32'h0 : resp_rdata;

    initial begin
        forever begin
            @(posedge ref_clk);
            if (mode != M_LAT && mode != M_HOLD) begin
                lat_ack = 1'b0;
                lat_cnt = 0;
            end else if (!lat_ack) begin
                if (fll_req_o) begin
                    if (lat_cnt >= lat) begin
                        if (!fll_wrn_o) fll_mem[fll_add_o] = fll_data_o;
                        resp_rdata = fll_mem[fll_add_o];
                        lat_ack = 1'b1;
                        lat_cnt = 0;
                    end else lat_cnt++;
                end else lat_cnt = 0;
            end else if (!fll_req_o && mode != M_HOLD) begin
                if (lat_cnt >= lat) begin
                    lat_ack = 1'b0;
                    lat_cnt = 0;
                end else lat_cnt++;
            end
        end
    end

    // ---------------- Request monitor ----------------
    int          req_rises = 0;
    int          early_drops = 0;
    int          unstable = 0;
    int          ack_run = 0;
    logic        prev_req = 1'b0;
    logic [1:0]  seen_add = '0;
    logic        seen_wrn = 1'b1;
    logic [31:0] seen_data = '0;

    initial begin
        forever begin
            @(negedge clk_i);
            if (rst_i) begin
                prev_req = 1'b0;
                ack_run  = 0;
            end else begin
                if (fll_req_o) begin
                    if (!prev_req) begin
                        req_rises++;
                        seen_add  = fll_add_o;
                        seen_wrn  = fll_wrn_o;
                        seen_data = fll_data_o;
                    end else if ({fll_add_o, fll_wrn_o, fll_data_o} !== {seen_add, seen_wrn, seen_data}) begin
                        unstable++;
                    end
                    ack_run = fll_ack_i ? ack_run + 1 : 0;
                end else if (prev_req) begin
                    // Request may only fall once the synchronized ack is high.
                    if (ack_run < 2) early_drops++;
                    ack_run = 0;
                end
                prev_req = fll_req_o;
            end
        end
    end

    // ---------------- Bus tasks ----------------
    task automatic apb_xfer(input logic [11:0] addr, input logic wr, input logic [31:0] wdata,
                            output logic [31:0] rdata, output logic err, output int ncyc,
                            output logic req_at_rdy);
        logic done;
        @(posedge clk_i); #1;
        bus.PADDR   = addr;
        bus.PWRITE  = wr;
        bus.PWDATA  = wdata;
        bus.PSEL    = 1'b1;
        bus.PENABLE = 1'b0;
        @(posedge clk_i); #1;
        bus.PENABLE = 1'b1;
        done = 1'b0; rdata = '0; err = 1'b0; ncyc = -1; req_at_rdy = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk_i);
            if (bus.PREADY) begin
                done       = 1'b1;
                rdata      = bus.PRDATA;
                err        = bus.PSLVERR;
                ncyc       = i;
                req_at_rdy = fll_req_o;
            end
        end
        check("apb_completes", 32'(done), 32'd1);
        @(posedge clk_i); #1;
        bus.PSEL    = 1'b0;
        bus.PENABLE = 1'b0;
        @(negedge clk_i);
        check("pready_one_cycle", 32'(bus.PREADY), 32'd0);
    endtask

    task automatic set_mode(input resp_mode_e m);
        mode = m;
        repeat (12) @(posedge clk_i);
    endtask

    task automatic check_reset_vals();
        check("rst_req",     32'(fll_req_o),   32'd0);
        check("rst_wrn",     32'(fll_wrn_o),   32'd1);
        check("rst_add",     32'(fll_add_o),   32'd0);
        check("rst_data",    fll_data_o,       32'd0);
        check("rst_prdata",  bus.PRDATA,       32'd0);
        check("rst_pready",  32'(bus.PREADY),  32'd0);
        check("rst_pslverr", 32'(bus.PSLVERR), 32'd0);
    endtask

    // ---------------- Model state and stimulus ----------------
    logic [31:0] model_regs [4];
    logic [31:0] exp_fll_data = '0;
    logic        exp_sticky = 1'b0;
    logic        exp_lock = 1'b0;

    logic [31:0] rd;
    logic        err;
    logic        rq;
    logic        got;
    int          n;
    int          rises0, drops0, unst0;
    int unsigned idx;
    logic        wr;
    logic [31:0] wd;
    logic [6:0]  hi;
    logic [31:0] exp_rd;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i = 1'b0;
        fll_lock_i = 1'b0;
        bus.PADDR = '0; bus.PWDATA = '0; bus.PWRITE = 1'b0; bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
        for (int i = 0; i < 4; i++) begin
            fll_mem[i]    = $urandom;
            model_regs[i] = fll_mem[i];
        end
        #2 rst_i = 1'b1;
        repeat (3) @(negedge clk_i);
        check_reset_vals();
        rst_i = 1'b0;
        repeat (2) @(posedge clk_i);

        // Loopback write: fixed T+7 completion.
        set_mode(M_LOOP);
        rises0 = req_rises; drops0 = early_drops; unst0 = unstable;
        apb_xfer(12'h008, 1'b1, 32'hDEADBEEF, rd, err, n, rq);
        exp_fll_data = 32'hDEADBEEF;
        check("t1_latency",  32'(n),   32'd7);
        check("t1_pslverr",  32'(err), 32'd0);
        check("t1_prdata",   rd,       32'd0);
        check("t1_rise",     32'(req_rises - rises0), 32'd1);
        check("t1_add",      32'(seen_add),  32'd2);
        check("t1_wrn",      32'(seen_wrn),  32'd0);
        check("t1_data",     seen_data,      32'hDEADBEEF);
        check("t1_stable",   32'(unstable - unst0),    32'd0);
        check("t1_drop_ack", 32'(early_drops - drops0), 32'd0);

        // Responder with 3 reference-clock latency, read register 1.
        set_mode(M_LAT);
        lat = 3;
        fll_mem[1] = 32'h12345678; model_regs[1] = 32'h12345678;
        drops0 = early_drops; unst0 = unstable;
        apb_xfer(12'h004, 1'b0, 32'h0, rd, err, n, rq);
        check("t2_prdata",   rd,             32'h12345678);
        check("t2_pslverr",  32'(err),       32'd0);
        check("t2_add",      32'(seen_add),  32'd1);
        check("t2_wrn",      32'(seen_wrn),  32'd1);
        check("t2_data_held", seen_data,     exp_fll_data);
        check("t2_drop_ack", 32'(early_drops - drops0), 32'd0);
        check("t2_stable",   32'(unstable - unst0),    32'd0);
        check("t2_wrn_idle", 32'(fll_wrn_o), 32'd1);

        // Ack never comes: REQ timeout after TMO cycles.
        set_mode(M_STUCK0);
        apb_xfer(12'h000, 1'b1, 32'hA5A50001, rd, err, n, rq);
        exp_fll_data = 32'hA5A50001;
        exp_sticky   = 1'b1;
        check("t3_latency", 32'(n),   32'(TMO + 1));
        check("t3_pslverr", 32'(err), 32'd1);
        check("t3_req_low", 32'(rq),  32'd0);
        check("t3_data_latched", fll_data_o, exp_fll_data);
        apb_xfer(12'h010, 1'b0, 32'h0, rd, err, n, rq);
        check("t3_status_set", rd, {30'd0, exp_sticky, exp_lock});
        apb_xfer(12'h010, 1'b1, 32'h2, rd, err, n, rq);
        exp_sticky = 1'b0;
        check("t3_w1c_latency", 32'(n),   32'd1);
        check("t3_w1c_pslverr", 32'(err), 32'd0);
        apb_xfer(12'h010, 1'b0, 32'h0, rd, err, n, rq);
        check("t3_status_clr", rd, 32'd0);

        // Ack rises and never drops: DROP-phase timeout.
        lat = 1;
        mode = M_HOLD;
        apb_xfer(12'h00C, 1'b0, 32'h0, rd, err, n, rq);
        exp_sticky = 1'b1;
        check("drop_tmo_pslverr", 32'(err), 32'd1);
        set_mode(M_LAT);
        apb_xfer(12'h010, 1'b0, 32'h0, rd, err, n, rq);
        check("drop_tmo_status", rd, {30'd0, exp_sticky, exp_lock});
        apb_xfer(12'h010, 1'b1, 32'h2, rd, err, n, rq);
        exp_sticky = 1'b0;

        // Stale ack: immediate error, no request.
        set_mode(M_STUCK1);
        rises0 = req_rises;
        apb_xfer(12'h00C, 1'b0, 32'h0, rd, err, n, rq);
        check("t4_latency", 32'(n),   32'd1);
        check("t4_pslverr", 32'(err), 32'd1);
        check("t4_no_req",  32'(req_rises - rises0), 32'd0);
        apb_xfer(12'h010, 1'b0, 32'h0, rd, err, n, rq);
        check("t4_no_sticky", rd, 32'd0);

        // Lock visible in STATUS; unmapped address errors locally.
        fll_lock_i = 1'b1; exp_lock = 1'b1;
        repeat (4) @(posedge clk_i);
        apb_xfer(12'h010, 1'b0, 32'h0, rd, err, n, rq);
        check("t5_status",  rd,       32'h1);
        check("t5_latency", 32'(n),   32'd1);
        rises0 = req_rises;
        apb_xfer(12'h018, 1'b1, 32'h55, rd, err, n, rq);
        check("t5_bad_pslverr", 32'(err), 32'd1);
        check("t5_bad_latency", 32'(n),   32'd1);
        check("t5_bad_no_req",  32'(req_rises - rises0), 32'd0);

        // Randomized traffic against the register-file model.
        set_mode(M_LAT);
        for (int t = 0; t < 40; t++) begin
            if (t % 8 == 0) begin
                exp_lock   = 1'($urandom_range(0, 1));
                fll_lock_i = exp_lock;
                repeat (4) @(posedge clk_i);
            end
            idx = $urandom_range(0, 7);
            wr  = 1'($urandom_range(0, 1));
            wd  = $urandom;
            hi  = 7'($urandom);
            lat = $urandom_range(0, 4);
            rises0 = req_rises; drops0 = early_drops; unst0 = unstable;
            apb_xfer({hi, idx[2:0], 2'b00}, wr, wd, rd, err, n, rq);
            if (idx < 4) begin
                if (wr) begin
                    model_regs[idx] = wd;
                    exp_fll_data    = wd;
                    exp_rd          = 32'd0;
                end else begin
                    exp_rd = model_regs[idx];
                end
                check("rnd_fll_pslverr", 32'(err), 32'd0);
                check("rnd_fll_prdata",  rd,       exp_rd);
                check("rnd_fll_rise",    32'(req_rises - rises0), 32'd1);
                check("rnd_fll_add",     32'(seen_add), idx);
                check("rnd_fll_wrn",     32'(seen_wrn), 32'(!wr));
                check("rnd_fll_data",    seen_data,     exp_fll_data);
                check("rnd_fll_stable",  32'(unstable - unst0),    32'd0);
                check("rnd_fll_dropack", 32'(early_drops - drops0), 32'd0);
            end else if (idx == 4) begin
                check("rnd_st_pslverr", 32'(err), 32'd0);
                check("rnd_st_latency", 32'(n),   32'd1);
                check("rnd_st_no_req",  32'(req_rises - rises0), 32'd0);
                if (!wr) check("rnd_st_prdata", rd, {30'd0, exp_sticky, exp_lock});
                else if (wd[1]) exp_sticky = 1'b0;
            end else begin
                check("rnd_bad_pslverr", 32'(err), 32'd1);
                check("rnd_bad_latency", 32'(n),   32'd1);
                check("rnd_bad_no_req",  32'(req_rises - rises0), 32'd0);
            end
        end

        // Reset asserted while a request is outstanding.
        set_mode(M_STUCK0);
        @(posedge clk_i); #1;
        bus.PADDR = 12'h008; bus.PWRITE = 1'b1; bus.PWDATA = 32'hCAFE0006;
        bus.PSEL = 1'b1; bus.PENABLE = 1'b0;
        @(posedge clk_i); #1;
        bus.PENABLE = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk_i);
            got = fll_req_o;
        end
        check("t6_req_seen", 32'(got), 32'd1);
        @(posedge clk_i); #3;
        rst_i = 1'b1;
        #1;
        check_reset_vals();
        bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        exp_fll_data = 32'd0;
        exp_sticky   = 1'b0;
        set_mode(M_LAT);
        lat = 2;
        wd = $urandom;
        drops0 = early_drops;
        apb_xfer(12'h008, 1'b1, wd, rd, err, n, rq);
        model_regs[2] = wd;
        check("t6_pslverr", 32'(err),      32'd0);
        check("t6_add",     32'(seen_add), 32'd2);
        check("t6_data",    seen_data,     wd);
        check("t6_dropack", 32'(early_drops - drops0), 32'd0);
        apb_xfer(12'h008, 1'b0, 32'h0, rd, err, n, rq);
        check("t6_readback", rd, model_regs[2]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end
endmodule
